// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - DRAM stand-in: word array, fixed-latency reads, credit-limited response FIFO.
// Optional request counters are enabled by defining DRAM_RESPONDER_STATS_EN.
module dram_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int READ_LAT  = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    output logic              req_rdy,
    input  logic              req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_en,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
`ifdef DRAM_RESPONDER_STATS_EN
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
`endif
    output logic              init_done
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [IDX_W-1:0]   w_clr_nxt;
    logic               w_clr_we;

    logic [DATA_W-1:0]  r_mem  [MEM_WORDS];
    logic [DATA_W-1:0]  r_pipe [READ_LAT];
    logic [READ_LAT-1:0] r_vld;
    logic [DATA_W-1:0]  r_fifo [RSP_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [CNT_W-1:0]   r_credits;

    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic               w_unused_addr;

    // Only the word index matters; everything else in the address aliases.
    assign w_idx         = req_addr[2 +: IDX_W];
    assign w_unused_addr = ^req_addr;

    assign w_accept = req_en && req_rdy;
    assign w_rd_acc = w_accept && req_cmd;
    assign w_wr_acc = w_accept && !req_cmd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = r_vld[READ_LAT-1];
    assign w_pop   = rsp_en && rsp_rdy;

    assign init_done = (r_state == ST_READY);
    assign req_rdy   = (r_state == ST_READY) && (r_credits < CNT_W'(RSP_DEPTH));
    assign rsp_en    = !w_empty;
    assign rsp_data  = w_empty ? '0 : r_fifo[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = r_clr_ptr;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_we  = 1'b1;
                w_clr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == IDX_W'(MEM_WORDS - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Storage needs no reset: the INIT sweep clears the array and valids guard the data paths.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_idx] <= req_data;
        end
        if (w_rd_acc) begin
            r_pipe[0] <= r_mem[w_idx];
        end
        for (int i = 1; i < READ_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
        if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= r_pipe[READ_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_credits <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_rd_acc, w_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

`ifdef DRAM_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (w_rd_acc) begin
                rd_count <= rd_count + 32'd1;
            end
            if (w_wr_acc) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed self-checking bench for dram_responder.
module tb_dram_responder;

    logic        clk;
    logic        rst;
    logic        req_en;
    logic        req_rdy;
    logic        req_cmd;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_en;
    logic        rsp_rdy;
    logic [31:0] rsp_data;
    logic        init_done;
`ifdef DRAM_RESPONDER_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int checks = 0;
    int errors = 0;

    dram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en),
        .req_rdy   (req_rdy),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_en    (rsp_en),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
`ifdef DRAM_RESPONDER_STATS_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A push into a full response FIFO would mean the credit scheme is broken.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.w_push && dut.w_full)) else begin
                errors++;
                $error("FAIL fifo_overflow obs=push_on_full exp=no_push_on_full");
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic cmd, input logic [31:0] addr, input logic [31:0] data);
        int k;
        req_en   = 1'b1;
        req_cmd  = cmd;
        req_addr = addr;
        req_data = data;
        k = 0;
        while (!req_rdy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) check("req_timeout", 32'(k), 32'd0);
        @(posedge clk); #1;
        req_en = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output int lat);
        lat = 0;
        while (!rsp_en && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_en ? rsp_data : 32'hxxxx_xxxx;
        @(posedge clk); #1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!req_rdy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(n), 32'd1024);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] got [$];
        int          lat;
        int          idx;
        int          stray;
        logic        rdy_s;
        logic        en_s;
        logic [31:0] data_s;

        rst      = 1'b1;
        req_en   = 1'b1;
        req_cmd  = 1'b1;
        req_addr = 32'h10;
        req_data = 32'h0;
        rsp_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        check("rst_rsp_en", {31'd0, rsp_en}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);

        // Init sweep with a read held pending the whole time.
        rst = 1'b0;
        wait_init("init_cycles");
        check("init_done", {31'd0, init_done}, 32'd1);
        @(posedge clk); #1;
        req_en = 1'b0;
        get_rsp(d, lat);
        check("init_read_data", d, 32'd0);
        check("init_read_lat", 32'(lat), 32'd4);

        do_req(1'b0, 32'h40, 32'hDEADBEEF);
        do_req(1'b1, 32'h40, 32'h0);
        get_rsp(d, lat);
        check("wr_rd_lat", 32'(lat), 32'd4);
        check("wr_rd_data", d, 32'hDEADBEEF);

        for (int i = 0; i < 6; i++) do_req(1'b0, 32'(i * 4), 32'(i + 1));

        // Six reads against a stalled consumer: only four credits exist.
        rsp_rdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            req_en   = (idx < 6);
            req_cmd  = 1'b1;
            req_addr = 32'(idx * 4);
            rdy_s    = req_rdy;
            @(posedge clk);
            if (req_en && rdy_s) idx++;
            #1;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
        check("bp_rsp_en_hold", {31'd0, rsp_en}, 32'd1);
        check("bp_rsp_data_hold", rsp_data, 32'd1);
        rsp_rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            req_en   = (idx < 6);
            req_addr = 32'(idx * 4);
            rdy_s    = req_rdy;
            en_s     = rsp_en;
            data_s   = rsp_data;
            @(posedge clk);
            if (req_en && rdy_s) idx++;
            if (en_s) got.push_back(data_s);
            #1;
        end
        req_en = 1'b0;
        check("bp_total_accepted", 32'(idx), 32'd6);
        check("bp_rsp_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_order_%0d", i), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, 32'(i + 1));
        end

        // Read then same-word write on the following cycle.
        do_req(1'b0, 32'h80, 32'h11);
        req_en   = 1'b1;
        req_cmd  = 1'b1;
        req_addr = 32'h80;
        check("stale_rdy", {31'd0, req_rdy}, 32'd1);
        @(posedge clk); #1;
        req_cmd  = 1'b0;
        req_data = 32'h22;
        @(posedge clk); #1;
        req_en = 1'b0;
        get_rsp(d, lat);
        check("stale_old_data", d, 32'h11);
        do_req(1'b1, 32'h80, 32'h0);
        get_rsp(d, lat);
        check("stale_new_data", d, 32'h22);

        do_req(1'b0, 32'h0000_1000, 32'hA5A5A5A5);
        do_req(1'b1, 32'h0000_0000, 32'h0);
        get_rsp(d, lat);
        check("alias_data", d, 32'hA5A5A5A5);

        // Three reads parked in the FIFO, then a reset pulse.
        rsp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) do_req(1'b1, 32'(i * 4), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_rsp_en_before", {31'd0, rsp_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rsp_en_async", {31'd0, rsp_en}, 32'd0);
        check("mid_init_done", {31'd0, init_done}, 32'd0);
`ifdef DRAM_RESPONDER_STATS_EN
        check("mid_rd_count", rd_count, 32'd0);
        check("mid_wr_count", wr_count, 32'd0);
`endif
        @(posedge clk); #1;
        rst     = 1'b0;
        rsp_rdy = 1'b1;
        stray   = 0;
        fork
            wait_init("reinit_cycles");
            begin
                for (int c = 0; c < 1100; c++) begin
                    @(negedge clk);
                    if (rsp_en) stray++;
                end
            end
        join_any
        disable fork;
        check("reinit_no_stale_rsp", 32'(stray), 32'd0);
        repeat (10) begin
            @(negedge clk);
            if (rsp_en) stray++;
        end
        check("reinit_quiet", 32'(stray), 32'd0);
        #1;
        do_req(1'b1, 32'h0, 32'h0);
        get_rsp(d, lat);
        check("reinit_cleared", d, 32'd0);
`ifdef DRAM_RESPONDER_STATS_EN
        check("stats_rd_count", rd_count, 32'd1);
        check("stats_wr_count", wr_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Slave end of the cache/DRAM request–response FIFO protocol. It sits below the cache arbiter and stands in for the DRAM.
- Accepts one request per cycle: cmd=1 is a read, cmd=0 is a write. Backs them with an on-chip word array.
- Returns read data in request order after a fixed pipeline latency, through a response FIFO that absorbs rsp_rdy backpressure.
- Writes produce no response.

Parameters:
- ADDR_W, 32, request byte-address width
- DATA_W, 32, data word width
- MEM_WORDS, 1024, array depth in words (power of 2, ≥4)
- READ_LAT, 4, cycles from read acceptance to earliest rsp_en (≥1)
- RSP_DEPTH, 4, response FIFO depth and maximum outstanding reads (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_en  in  1  request valid
- req_rdy  out  1  request accept
- req_cmd  in  1  1=read, 0=write
- req_addr  in  ADDR_W  byte address
- req_data  in  DATA_W  write data
- rsp_en  out  1  response valid
- rsp_rdy  in  1  response accept
- rsp_data  out  DATA_W  read data
- init_done  out  1  array clear complete

Behaviour:
- The interface uses one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: req_rdy=0, rsp_en=0, rsp_data=0, init_done=0. FIFO pointers, pipeline valids and credit counter are all 0. FSM state is INIT with clear pointer 0.
- Word index = req_addr[2 +: log2(MEM_WORDS)]. Bits [1:0] and the upper bits are ignored, so out-of-range addresses alias.
- FSM states:
  - INIT: writes 0 to word[clr_ptr] each cycle and increments clr_ptr. After MEM_WORDS cycles it moves to READY. req_rdy=0 throughout.
  - READY: init_done=1. Stays in READY until rst.
- Handshakes:
  - Request is accepted on a cycle with req_en && req_rdy.
  - Response is transferred on a cycle with rsp_en && rsp_rdy.
  - req_rdy depends only on state and credits, never combinationally on req_en or rsp_rdy.
- Credits:
  - credits = reads in flight in the pipeline + FIFO occupancy, range 0..RSP_DEPTH.
  - req_rdy = (state==READY) && (credits < RSP_DEPTH). This applies to both cmd values.
  - Read accepted: credits +1. Response popped: credits −1. Both in the same cycle: unchanged.
- Write:
  - The array is updated at the acceptance edge.
  - A read accepted on a later cycle sees the new data.
- Read:
  - The array is sampled at the acceptance edge.
  - Data passes through READ_LAT−1 registered stages, each with a valid bit, then is pushed into the FIFO.
  - With an empty FIFO, rsp_en rises READ_LAT cycles after the acceptance edge.
  - A write to the same word accepted after the read does not affect the returned data.
- FIFO output:
  - rsp_en = !empty. rsp_data = head entry, valid only while rsp_en=1.
  - While rsp_en=1 && rsp_rdy=0, rsp_en and rsp_data hold stable.
- FIFO boundaries:
  - Push and pop in the same cycle are legal when full or empty. On an empty FIFO the pushed word appears at the next cycle, not the same cycle.
  - The credit scheme guarantees a push never meets a full FIFO. A push to a full FIFO is a design error; the bench asserts against it.
- Ordering: responses are strictly in read-acceptance order.
- rst mid-operation: in-flight reads and FIFO contents are discarded, the FSM returns to INIT, and the array is re-cleared.
- Back-to-back: one request per cycle at full rate while credits allow.

Optional Feature:
- Macro DRAM_RESPONDER_STATS_EN.
- Defined: adds ports rd_count (out, 32) and wr_count (out, 32).
  - They count accepted reads and accepted writes, wrap at 2^32, and reset to 0.
  - They do not count in INIT.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Init: release rst, hold req_en=1 → req_rdy=0 for exactly 1024 cycles, then init_done=1 and req_rdy=1. A read of addr 0x10 returns 0x00000000.
- Write/read latency: write 0xDEADBEEF to 0x40, then read 0x40 with rsp_rdy=1 → rsp_en rises exactly 4 cycles after the read acceptance edge, rsp_data=0xDEADBEEF.
- Backpressure/credits: rsp_rdy=0, issue 6 reads to 0x0,0x4,…,0x14 holding data 1..6 → exactly 4 accepted and req_rdy=0 afterwards. Raise rsp_rdy → data 1,2,3,4 in order, then the remaining 2 reads are accepted.
- Stale read: read 0x80 (holding 0x11) accepted, write 0x22 to 0x80 next cycle → response 0x11. A subsequent read returns 0x22.
- Alias/wrap: write 0xA5A5A5A5 to 0x00001000 (MEM_WORDS=1024) → a read of 0x00000000 returns 0xA5A5A5A5.
- Reset mid-flight: 3 reads outstanding, pulse rst for 1 cycle → rsp_en=0 immediately, re-init takes 1024 cycles, and no stale response ever appears. With DRAM_RESPONDER_STATS_EN, rd_count=0.
